// File: rtl/roce_width_pkg.sv
// Shared width helpers and the packed AXI-stream word used by the RoCE width adapters.
package roce_width_pkg;

   // Default widths of the 64-bit build.
   localparam int DEF_S_WIDTH = 64;
   localparam int DEF_M_WIDTH = 512;
   localparam int DEF_DEST_W  = 1;

   // Number of narrow beats that make up one wide word.
   function automatic int calc_ratio(input int m_width, input int s_width);
      return m_width / s_width;
   endfunction

   // Width of a slot index able to address every narrow beat of a word.
   function automatic int calc_idx_w(input int ratio);
      return (ratio < 2) ? 1 : $clog2(ratio);
   endfunction

   // True when v is a non-zero power of two.
   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   localparam int RATIO = calc_ratio(DEF_M_WIDTH, DEF_S_WIDTH);
   localparam int IDX_W = calc_idx_w(RATIO);

   // One complete wide word: used for the accumulator, the hold slot and the output register.
   typedef struct packed {
      logic [DEF_M_WIDTH-1:0]   data;
      logic [DEF_M_WIDTH/8-1:0] keep;
      logic                     last;
      logic [DEF_DEST_W-1:0]    dest;
   } axis_word_t;

endpackage

// File: rtl/roce_mem_write_upsizer.sv
// Packs the RoCE core's narrow memory-write data stream into wide DMA write beats.
// Beat k of a word lands in lane k (little-endian). A completed word that cannot
// enter the output register is frozen in the accumulator (acc_done) and input
// is paused until the output register frees up.
module roce_mem_write_upsizer
   import roce_width_pkg::*;
#(
   parameter int S_WIDTH = DEF_S_WIDTH,
   parameter int M_WIDTH = DEF_M_WIDTH,
   parameter int DEST_W  = DEF_DEST_W
) (
   input  logic                 net_clk,
   input  logic                 net_aresetn,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [S_WIDTH-1:0]   s_axis_tdata,
   input  logic [S_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                 s_axis_tlast,
   input  logic [DEST_W-1:0]    s_axis_tdest,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [M_WIDTH-1:0]   m_axis_tdata,
   output logic [M_WIDTH/8-1:0] m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic [DEST_W-1:0]    m_axis_tdest
);

   localparam int N_SLOTS = calc_ratio(M_WIDTH, S_WIDTH);
   localparam int SLOT_W  = calc_idx_w(N_SLOTS);
   localparam int SK_W    = S_WIDTH / 8;

   // Reject width combinations the lane packing cannot represent; the shared word
   // type is sized for the default build, so the wide side must match it.
   generate
      if ((M_WIDTH % S_WIDTH) != 0 || !is_pow2(N_SLOTS) || N_SLOTS < 2 ||
          (S_WIDTH % 8) != 0 || M_WIDTH != DEF_M_WIDTH || DEST_W != DEF_DEST_W) begin : g_param_err
         $error("roce_mem_write_upsizer: unsupported S_WIDTH/M_WIDTH/DEST_W combination");
      end
   endgenerate

   logic [SLOT_W-1:0] idx_reg;
   axis_word_t        acc_reg;
   axis_word_t        out_reg;
   axis_word_t        beat_word;
   logic              acc_done_reg;
   logic              out_valid_reg;
   logic              s_fire;
   logic              beat_completes;
   logic              out_free;

   assign s_axis_tready  = ~acc_done_reg;
   assign s_fire         = s_axis_tvalid & ~acc_done_reg;
   assign beat_completes = (idx_reg == SLOT_W'(N_SLOTS - 1)) | s_axis_tlast;
   // The output register can take a word if it is empty or is being drained now.
   assign out_free       = ~out_valid_reg | m_axis_tready;

   assign m_axis_tvalid = out_valid_reg;
   assign m_axis_tdata  = out_reg.data;
   assign m_axis_tkeep  = out_reg.keep;
   assign m_axis_tlast  = out_reg.last;
   assign m_axis_tdest  = out_reg.dest;

   // Accumulator contents after writing the current input beat into its lane.
   always_comb begin
      beat_word = (idx_reg == '0) ? axis_word_t'('0) : acc_reg;
      if (idx_reg == '0) begin
         beat_word.dest = s_axis_tdest;
      end
      for (int i = 0; i < N_SLOTS; i++) begin
         if (idx_reg == SLOT_W'(i)) begin
            beat_word.data[i*S_WIDTH +: S_WIDTH] = s_axis_tdata;
            beat_word.keep[i*SK_W +: SK_W]       = s_axis_tkeep;
         end
      end
      beat_word.last = s_axis_tlast;
   end

   // Accumulator, hold flag and output register update.
   always_ff @(posedge net_clk or negedge net_aresetn) begin
      if (!net_aresetn) begin
         idx_reg       <= '0;
         acc_reg       <= '0;
         out_reg       <= '0;
         acc_done_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         if (s_fire) begin
            acc_reg <= beat_word;
            idx_reg <= beat_completes ? '0 : idx_reg + SLOT_W'(1);
         end

         if (acc_done_reg) begin
            // Input is paused, so the frozen word moves out as soon as there is room.
            if (out_free) begin
               out_reg       <= acc_reg;
               out_valid_reg <= 1'b1;
               acc_done_reg  <= 1'b0;
            end
         end else if (s_fire && beat_completes) begin
            if (out_free) begin
               out_reg       <= beat_word;
               out_valid_reg <= 1'b1;
            end else begin
               acc_done_reg <= 1'b1;
            end
         end else if (out_valid_reg && m_axis_tready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_roce_mem_write_upsizer.sv
// Self-checking bench for roce_mem_write_upsizer: directed table, backpressure,
// same-cycle, reset and randomized traffic against a beat-list reference model.
module tb_roce_mem_write_upsizer;
   import roce_width_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [63:0]  s_data = '0;
   logic [7:0]   s_keep = '0;
   logic         s_last = 1'b0;
   logic [0:0]   s_dest = '0;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic [511:0] m_data;
   logic [63:0]  m_keep;
   logic         m_last;
   logic [0:0]   m_dest;

   always #5 clk = ~clk;

   roce_mem_write_upsizer dut (
      .net_clk       (clk),
      .net_aresetn   (rst_n),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready),
      .s_axis_tdata  (s_data),
      .s_axis_tkeep  (s_keep),
      .s_axis_tlast  (s_last),
      .s_axis_tdest  (s_dest),
      .m_axis_tvalid (m_valid),
      .m_axis_tready (m_ready),
      .m_axis_tdata  (m_data),
      .m_axis_tkeep  (m_keep),
      .m_axis_tlast  (m_last),
      .m_axis_tdest  (m_dest)
   );

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endfunction

   // Reference model: collect accepted beats, emit a word after 8 beats or on last.
   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
      logic [0:0]   dest;
   } exp_t;

   logic [63:0] pd[$];
   logic [7:0]  pk[$];
   logic [0:0]  pdest;
   exp_t        expq[$];
   exp_t        e_pop;
   exp_t        e_new;
   int          words_out = 0;
   int          beats_in = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pd.delete();
         pk.delete();
      end else begin
         if (m_valid && m_ready) begin
            words_out++;
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word got=%0h want=none", m_data);
            end else begin
               e_pop = expq.pop_front();
               chk("word_data", m_data, e_pop.data);
               chk("word_keep", 512'(m_keep), 512'(e_pop.keep));
               chk("word_last", 512'(m_last), 512'(e_pop.last));
               chk("word_dest", 512'(m_dest), 512'(e_pop.dest));
               $display("word %0d data=%0h keep=%0h last=%0b dest=%0d", words_out, m_data, m_keep, m_last, m_dest);
            end
         end
         if (s_valid && s_ready) begin
            beats_in++;
            if (pd.size() == 0) pdest = s_dest;
            pd.push_back(s_data);
            pk.push_back(s_keep);
            if (pd.size() == 8 || s_last) begin
               e_new.data = '0;
               e_new.keep = '0;
               for (int i = 0; i < pd.size(); i++) begin
                  e_new.data[64*i +: 64] = pd[i];
                  e_new.keep[8*i +: 8]   = pk[i];
               end
               e_new.last = s_last;
               e_new.dest = pdest;
               expq.push_back(e_new);
               pd.delete();
               pk.delete();
            end
         end
      end
   end

   // Present one beat and hold it until accepted (bounded); returns at posedge+1.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [0:0] dst);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      s_dest  = dst;
      @(negedge clk);
      while (!s_ready && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (t >= 200) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got=stalled want=accepted");
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   // Wait until the model has no outstanding words and the output is idle (bounded).
   task automatic wait_drain();
      int t;
      t = 0;
      while ((expq.size() != 0 || m_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout got=pending want=empty");
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int           n;
      logic [7:0]   keep;
      logic [0:0]   dest;
      logic [63:0]  d0;
      logic [511:0] exp_data;
      logic [63:0]  exp_keep;
   } vec_t;

   vec_t vecs[3];
   int   acc_before;
   int   words_before;
   bit   rand_on;

   initial begin
      vecs[0] = '{8, 8'hFF, 1'b0, 64'h0,
                  {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0},
                  64'hFFFF_FFFF_FFFF_FFFF};
      vecs[1] = '{3, 8'hFF, 1'b0, 64'h0,
                  {320'h0, 64'h2, 64'h1, 64'h0},
                  64'h0000_0000_00FF_FFFF};
      vecs[2] = '{1, 8'h0F, 1'b1, 64'h0123_4567_89AB_CDEF,
                  {448'h0, 64'h0123_4567_89AB_CDEF},
                  64'h0F};

      // Reset state.
      #1;
      chk("rst_m_valid", 512'(m_valid), 512'(0));
      chk("rst_m_data", m_data, 512'(0));
      chk("rst_m_keep", 512'(m_keep), 512'(0));
      chk("rst_m_last", 512'(m_last), 512'(0));
      chk("rst_m_dest", 512'(m_dest), 512'(0));
      chk("rst_s_ready", 512'(s_ready), 512'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: full word, short packet, single partial beat.
      m_ready = 1'b1;
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            send_beat(vecs[v].d0 + 64'(i), vecs[v].keep, (i == vecs[v].n - 1), vecs[v].dest);
         end
         chk("tbl_latency_valid", 512'(m_valid), 512'(1));
         chk("tbl_data", m_data, vecs[v].exp_data);
         chk("tbl_keep", 512'(m_keep), 512'(vecs[v].exp_keep));
         chk("tbl_last", 512'(m_last), 512'(1));
         chk("tbl_dest", 512'(m_dest), 512'(vecs[v].dest));
         wait_drain();
      end

      // Backpressure: 24 beats against a 30-cycle stall.
      m_ready      = 1'b0;
      acc_before   = beats_in;
      words_before = words_out;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               send_beat({$urandom, $urandom}, 8'hFF, (i % 8 == 7), 1'b0);
            end
         end
         begin
            repeat (30) @(negedge clk);
            chk("bp_accepted", 512'(beats_in - acc_before), 512'(16));
            chk("bp_s_ready_low", 512'(s_ready), 512'(0));
            chk("bp_m_valid_held", 512'(m_valid), 512'(1));
            @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      wait_drain();
      chk("bp_word_count", 512'(words_out - words_before), 512'(3));

      // Same cycle: drain + hold transfer, then a completing beat while draining.
      m_ready      = 1'b0;
      words_before = words_out;
      for (int i = 0; i < 16; i++) begin
         send_beat(64'h100 + 64'(i), 8'hFF, (i % 8 == 7), 1'b1);
      end
      fork
         send_beat(64'hC0FFEE, 8'h03, 1'b1, 1'b0);
         begin
            @(posedge clk);
            #1;
            m_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("sim_s_ready_after_clear", 512'(s_ready), 512'(1));
            chk("sim_m_valid", 512'(m_valid), 512'(1));
         end
      join
      wait_drain();
      chk("sim_word_count", 512'(words_out - words_before), 512'(3));

      // Randomized traffic with random downstream stalls.
      rand_on = 1'b1;
      words_before = words_out;
      fork
         begin
            logic [0:0] dst;
            logic       lst;
            dst = 1'b0;
            for (int i = 0; i < 300; i++) begin
               lst = ($urandom_range(0, 4) == 0);
               send_beat({$urandom, $urandom}, 8'($urandom), lst, dst);
               if (lst) dst = 1'($urandom);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            send_beat(64'hE0F, 8'hFF, 1'b1, dst);
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset mid-word: partial word discarded, fresh word delivered.
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_beat(64'hBAD0 + 64'(i), 8'hFF, 1'b0, 1'b1);
      end
      rst_n = 1'b0;
      #2;
      chk("mid_rst_m_valid", 512'(m_valid), 512'(0));
      chk("mid_rst_m_data", m_data, 512'(0));
      chk("mid_rst_m_keep", 512'(m_keep), 512'(0));
      chk("mid_rst_m_last", 512'(m_last), 512'(0));
      chk("mid_rst_s_ready", 512'(s_ready), 512'(1));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      words_before = words_out;
      for (int i = 0; i < 8; i++) begin
         send_beat(64'hF0 + 64'(i), 8'hFF, (i == 7), 1'b0);
      end
      chk("rst_fresh_data", m_data,
          {64'hF7, 64'hF6, 64'hF5, 64'hF4, 64'hF3, 64'hF2, 64'hF1, 64'hF0});
      wait_drain();
      chk("rst_word_count", 512'(words_out - words_before), 512'(1));

      chk("end_expq_empty", 512'(expq.size()), 512'(0));
      chk("end_partial_empty", 512'(pd.size()), 512'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
